// File: rtl/redmule_pkg.sv
// -----------------------------------------------------------------------------
// redmule_pkg
// Shared types and constants for the RedMulE wide TCDM data port.
//   redmule_default_data_req_t : streamer -> TCDM request bundle
//   redmule_default_data_rsp_t : TCDM -> streamer response bundle
//   TCDM_RSP_OK / TCDM_RSP_ERR : r_opc codes
//   TCDM_LFSR_SEED             : reset value of the grant-stall LFSR
//   tcdm_lfsr_next()           : one step of x^16+x^14+x^13+x^11+1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package redmule_pkg;

    localparam int unsigned DATA_W  = 256;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned BOFFS_W = DATA_W / 32;
    localparam int unsigned USER_W  = 4;

    localparam logic TCDM_RSP_OK  = 1'b0;
    localparam logic TCDM_RSP_ERR = 1'b1;

    localparam logic [15:0] TCDM_LFSR_SEED = 16'hACE1;

    // wen = 1 means read; lrdy is the requester's readiness to take a response.
    typedef struct packed {
        logic                req;
        logic                wen;
        logic [BE_W-1:0]     be;
        logic [BOFFS_W-1:0]  boffs;
        logic [ADDR_W-1:0]   add;
        logic [DATA_W-1:0]   data;
        logic                lrdy;
        logic [USER_W-1:0]   user;
    } redmule_default_data_req_t;

    typedef struct packed {
        logic                gnt;
        logic                r_valid;
        logic [DATA_W-1:0]   r_data;
        logic                r_opc;
        logic [USER_W-1:0]   r_user;
    } redmule_default_data_rsp_t;

    // Right-shifting Fibonacci form; taps 0,2,3,5 realise x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] tcdm_lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/redmule_tcdm_rsp_fifo.sv
// -----------------------------------------------------------------------------
// redmule_tcdm_rsp_fifo
// Synchronous FIFO holding {r_data, r_opc, r_user} entries of the responder.
//   clk_i, rst_i : clock, asynchronous active-high reset (pointers only)
//   push_i/data_i: write an entry
//   pop_i        : drop the head entry
//   data_o       : head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module redmule_tcdm_rsp_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_i)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr[AW-1:0]] <= data_i;
    end

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_o  = mem[rd_ptr[AW-1:0]];

    // The credit limit upstream keeps this FIFO from ever overflowing.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/redmule_tcdm_responder.sv
// -----------------------------------------------------------------------------
// redmule_tcdm_responder
// Responder end of the RedMulE wide TCDM port, backed by an internal memory.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   stall_en_i       : enable pseudo-random grant stalls
//   req_i            : request bundle (req, wen=1 read, be, boffs, add, data, lrdy, user)
//   rsp_o            : response bundle (gnt, r_valid, r_data, r_opc, r_user)
//   n_outstanding_o  : granted responses not yet consumed
//   err_cnt_o        : saturating count of out-of-range accesses
// Handshake: a request is accepted on the rising edge where req && gnt; a
// response is consumed on the rising edge where r_valid && lrdy, and while
// r_valid is high and lrdy is low the response fields hold their value.
// DW must equal redmule_pkg::DATA_W since the port bundles are sized by it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module redmule_tcdm_responder
    import redmule_pkg::*;
#(
    parameter int unsigned DW           = DATA_W,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned OUTSTANDING  = 4,
    parameter int unsigned STALL_MASK_W = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              stall_en_i,
    input  redmule_default_data_req_t         req_i,
    output redmule_default_data_rsp_t         rsp_o,
    output logic [$clog2(OUTSTANDING):0]      n_outstanding_o,
    output logic [15:0]                       err_cnt_o
);

    localparam int unsigned OFFS_W = $clog2(DW / 8);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W  = $clog2(OUTSTANDING) + 1;
    localparam int unsigned ENT_W  = DW + 1 + USER_W;

    // ---------------------------------------------------------------- decode
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              oor;

    assign off  = req_i.add - BASE_ADDR;
    assign word = off >> OFFS_W;
    assign oor  = (req_i.add < BASE_ADDR) || (word >= ADDR_W'(MEM_WORDS));
    assign idx  = word[IDX_W-1:0];

    // ---------------------------------------------------------------- stall LFSR
    logic [15:0] lfsr;
    logic        stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr <= TCDM_LFSR_SEED;
        else       lfsr <= tcdm_lfsr_next(lfsr);
    end

    if (STALL_MASK_W > 0) begin : g_stall
        assign stall = stall_en_i && (lfsr[STALL_MASK_W-1:0] == '0);
    end else begin : g_no_stall
        assign stall = 1'b0;
    end

    // ---------------------------------------------------------------- grant / credits
    logic [CNT_W-1:0] n_out;
    logic             gnt;
    logic             accept;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    // Gated by reset so that rsp_o reads all zero while reset is held.
    assign gnt    = req_i.req && !stall && (n_out < CNT_W'(OUTSTANDING)) && !rst_i;
    assign accept = gnt;
    assign pop    = !fifo_empty && req_i.lrdy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_out <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   n_out <= n_out + CNT_W'(1);
                2'b01:   n_out <= n_out - CNT_W'(1);
                default: n_out <= n_out;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (accept && oor && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end

    assign n_outstanding_o = n_out;

    // ---------------------------------------------------------------- memory
    logic [DW-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (accept && !req_i.wen && !oor) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (req_i.be[i]) mem[idx][8*i +: 8] <= req_i.data[8*i +: 8];
            end
        end
    end

    // Read data is taken before this edge's write, which cannot target a
    // read request anyway: one request per cycle.
    logic [DW-1:0]    new_data;
    logic             new_opc;
    logic [ENT_W-1:0] new_entry;

    assign new_data  = (req_i.wen && !oor) ? mem[idx] : '0;
    assign new_opc   = oor ? TCDM_RSP_ERR : TCDM_RSP_OK;
    assign new_entry = {new_data, new_opc, req_i.user};

    // ---------------------------------------------------------------- latency pipe
    // The FIFO register itself supplies one cycle, so LATENCY-1 extra stages.
    logic             push;
    logic [ENT_W-1:0] push_data;

    if (LATENCY == 1) begin : g_direct
        assign push      = accept;
        assign push_data = new_entry;
    end else begin : g_pipe
        localparam int unsigned D = LATENCY - 1;
        logic [D-1:0]     pipe_valid;
        logic [ENT_W-1:0] pipe_data [D];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pipe_valid <= '0;
            end else begin
                pipe_valid[0] <= accept;
                for (int i = 1; i < D; i++) pipe_valid[i] <= pipe_valid[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept) pipe_data[0] <= new_entry;
            for (int i = 1; i < D; i++) pipe_data[i] <= pipe_data[i-1];
        end

        assign push      = pipe_valid[D-1];
        assign push_data = pipe_data[D-1];
    end

    // ---------------------------------------------------------------- response FIFO
    logic [ENT_W-1:0] head;

    redmule_tcdm_rsp_fifo #(
        .W     (ENT_W),
        .DEPTH (OUTSTANDING)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        rsp_o         = '0;
        rsp_o.gnt     = gnt;
        rsp_o.r_valid = !fifo_empty;
        if (!fifo_empty) begin
            {rsp_o.r_data, rsp_o.r_opc, rsp_o.r_user} = head;
        end
    end

    // boffs is deliberately ignored; fifo_full is implied by the credit count.
    logic unused_ok;
    assign unused_ok = ^{req_i.boffs, fifo_full, stall_en_i};

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
`timescale 1ns/1ps
module tb_redmule_tcdm_responder;
    import redmule_pkg::*;

    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam int          MEM_WORDS = 1024;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              opc;
        logic [USER_W-1:0] user;
    } exp_t;

    // ---------------------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUTs
    redmule_default_data_req_t req1, req3;
    redmule_default_data_rsp_t rsp1, rsp3;
    logic        stall1, stall3;
    logic [2:0]  nout1, nout3;
    logic [15:0] err1, err3;

    redmule_tcdm_responder #(.LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .stall_en_i(stall1), .req_i(req1), .rsp_o(rsp1),
        .n_outstanding_o(nout1), .err_cnt_o(err1)
    );

    redmule_tcdm_responder #(.LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .stall_en_i(stall3), .req_i(req3), .rsp_o(rsp3),
        .n_outstanding_o(nout3), .err_cnt_o(err3)
    );

    // ---------------------------------------------------------------- scoreboard
    exp_t              exp_q1[$], exp_q3[$];
    int                acc_q1[$], acc_q3[$];
    logic [DATA_W-1:0] mem1 [int];
    logic [DATA_W-1:0] mem3 [int];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [31:0] t;
        t = 32'(i) ^ 32'h5A5A_0000;
        return {8{t}};
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && ((o / 32) < MEM_WORDS);
    endfunction

    // Reference behaviour of one accepted request; updates the bench's memory image.
    function automatic exp_t model_step(input bit sel, input redmule_default_data_req_t r);
        exp_t              e;
        int                w;
        logic [DATA_W-1:0] cur;
        e.user = r.user;
        e.data = '0;
        e.opc  = 1'b0;
        if (!in_range(r.add)) begin
            e.opc = 1'b1;
            return e;
        end
        w = int'((r.add - BASE) / 32);
        if (r.wen) begin
            e.data = sel ? mem3[w] : mem1[w];
        end else begin
            cur = sel ? (mem3.exists(w) ? mem3[w] : '0) : (mem1.exists(w) ? mem1[w] : '0);
            for (int i = 0; i < BE_W; i++) if (r.be[i]) cur[8*i +: 8] = r.data[8*i +: 8];
            if (sel) mem3[w] = cur;
            else     mem1[w] = cur;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   a;
        #2;
        if (!rst) begin
            if (rsp1.r_valid && req1.lrdy) begin
                n_checks++;
                if (exp_q1.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb1_unexpected: got response data=%h with none expected", rsp1.r_data);
                end else begin
                    e = exp_q1.pop_front();
                    a = acc_q1.pop_front();
                    if ({rsp1.r_data, rsp1.r_opc, rsp1.r_user} !== e) begin
                        n_errors++;
                        $display("FAIL sb1_rsp: got %h expected %h", {rsp1.r_data, rsp1.r_opc, rsp1.r_user}, e);
                    end
                    n_checks++;
                    if (cyc - a < 1) begin
                        n_errors++;
                        $display("FAIL sb1_latency: got %0d cycles expected >= 1", cyc - a);
                    end
                end
            end
            if (req1.req && rsp1.gnt) begin
                exp_q1.push_back(model_step(1'b0, req1));
                acc_q1.push_back(cyc);
            end
            if (rsp3.r_valid && req3.lrdy) begin
                n_checks++;
                if (exp_q3.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb3_unexpected: got response data=%h with none expected", rsp3.r_data);
                end else begin
                    e = exp_q3.pop_front();
                    a = acc_q3.pop_front();
                    if ({rsp3.r_data, rsp3.r_opc, rsp3.r_user} !== e) begin
                        n_errors++;
                        $display("FAIL sb3_rsp: got %h expected %h", {rsp3.r_data, rsp3.r_opc, rsp3.r_user}, e);
                    end
                    n_checks++;
                    if (cyc - a < 3) begin
                        n_errors++;
                        $display("FAIL sb3_latency: got %0d cycles expected >= 3", cyc - a);
                    end
                end
            end
            if (req3.req && rsp3.gnt) begin
                exp_q3.push_back(model_step(1'b1, req3));
                acc_q3.push_back(cyc);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic drive1(input logic wen, input logic [31:0] add, input logic [DATA_W-1:0] data,
                          input logic [BE_W-1:0] be, input logic [USER_W-1:0] user, output int acc);
        int t;
        req1.req = 1'b1; req1.wen = wen; req1.add = add; req1.data = data;
        req1.be = be; req1.user = user; req1.boffs = '0;
        t = 0;
        #1;
        while (!rsp1.gnt && t < 100) begin
            @(negedge clk); #1; t++;
        end
        if (!rsp1.gnt) begin
            n_checks++; n_errors++;
            $display("FAIL drive1_timeout: gnt stayed 0 for %0d cycles, required 1", t);
        end
        acc = cyc;
        @(negedge clk);
        req1.req = 1'b0;
    endtask

    task automatic drive3(input logic wen, input logic [31:0] add, input logic [DATA_W-1:0] data,
                          input logic [BE_W-1:0] be, input logic [USER_W-1:0] user, output int waits);
        req3.req = 1'b1; req3.wen = wen; req3.add = add; req3.data = data;
        req3.be = be; req3.user = user; req3.boffs = '0;
        waits = 0;
        #1;
        while (!rsp3.gnt && waits < 100) begin
            @(negedge clk); #1; waits++;
        end
        if (!rsp3.gnt) begin
            n_checks++; n_errors++;
            $display("FAIL drive3_timeout: gnt stayed 0 for %0d cycles, required 1", waits);
        end
        @(negedge clk);
        req3.req = 1'b0;
    endtask

    task automatic wait_drain(input bit sel);
        int t;
        t = 0;
        while (((sel ? exp_q3.size() : exp_q1.size()) != 0) && t < 200) begin
            @(negedge clk); #3; t++;
        end
        if ((sel ? exp_q3.size() : exp_q1.size()) != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain%0d: %0d responses still pending, required 0", sel ? 3 : 1,
                     sel ? exp_q3.size() : exp_q1.size());
        end
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (rsp1 !== '0) begin n_errors++; $display("FAIL reset_rsp1: got %h required 0", rsp1); end
        n_checks++;
        if (rsp3 !== '0) begin n_errors++; $display("FAIL reset_rsp3: got %h required 0", rsp3); end
        n_checks++;
        if (nout1 !== 3'd0 || nout3 !== 3'd0) begin
            n_errors++; $display("FAIL reset_nout: got %0d/%0d required 0/0", nout1, nout3);
        end
        n_checks++;
        if (err1 !== 16'd0 || err3 !== 16'd0) begin
            n_errors++; $display("FAIL reset_err: got %0d/%0d required 0/0", err1, err3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int a;
        logic [DATA_W-1:0] v;
        v = {{7{32'h1234_5678}}, 32'hDEAD_BEEF};
        req1.lrdy = 1'b1;
        drive1(1'b0, BASE + 32, v, '1, 4'h1, a);
        drive1(1'b1, BASE + 32, '0, '0, 4'h2, a);
        #1;
        n_checks++;
        if (rsp1.r_valid !== 1'b1) begin n_errors++; $display("FAIL wr_valid: got %b required 1 one cycle after accept", rsp1.r_valid); end
        n_checks++;
        if (rsp1.r_data !== v) begin n_errors++; $display("FAIL wr_data: got %h required %h", rsp1.r_data, v); end
        n_checks++;
        if (rsp1.r_opc !== 1'b0 || rsp1.r_user !== 4'h2) begin
            n_errors++; $display("FAIL wr_opc_user: got %b/%h required 0/2", rsp1.r_opc, rsp1.r_user);
        end
        wait_drain(1'b0);
    endtask

    task automatic test_byte_enables;
        int a;
        logic [DATA_W-1:0] v;
        v = {{28{8'hFF}}, 32'h0000_0000};
        drive1(1'b0, BASE + 64, '1, '1, 4'h3, a);
        drive1(1'b0, BASE + 64, '0, 32'h0000_000F, 4'h4, a);
        drive1(1'b1, BASE + 64, '0, '0, 4'h5, a);
        #1;
        n_checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== v) begin
            n_errors++; $display("FAIL be_data: got %b/%h required 1/%h", rsp1.r_valid, rsp1.r_data, v);
        end
        wait_drain(1'b0);
    endtask

    task automatic test_backpressure;
        int a;
        int gcount;
        logic [DATA_W-1:0] held;
        for (int i = 0; i < 6; i++) drive1(1'b0, BASE + 32'((8 + i) * 32), pat(8 + i), '1, 4'(i), a);
        wait_drain(1'b0);
        req1.lrdy = 1'b0;
        gcount = 0;
        for (int i = 0; i < 6; i++) begin
            req1.req = 1'b1; req1.wen = 1'b1; req1.add = BASE + 32'((8 + i) * 32);
            req1.be = '0; req1.data = '0; req1.user = 4'(i + 8);
            #1;
            if (rsp1.gnt) gcount++;
            if (i >= 4) begin
                n_checks++;
                if (rsp1.gnt !== 1'b0) begin n_errors++; $display("FAIL bp_gnt_low: read %0d got gnt %b required 0", i, rsp1.gnt); end
            end
            @(negedge clk);
        end
        req1.req = 1'b0;
        #1;
        n_checks++;
        if (gcount != 4) begin n_errors++; $display("FAIL bp_grants: got %0d required 4", gcount); end
        n_checks++;
        if (nout1 !== 3'd4) begin n_errors++; $display("FAIL bp_nout: got %0d required 4", nout1); end
        held = rsp1.r_data;
        n_checks++;
        if (held !== pat(8)) begin n_errors++; $display("FAIL bp_head: got %h required %h", held, pat(8)); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== held) begin
            n_errors++; $display("FAIL bp_hold: got %b/%h required 1/%h", rsp1.r_valid, rsp1.r_data, held);
        end
        @(negedge clk);
        req1.lrdy = 1'b1;
        drive1(1'b1, BASE + 32'(8 * 32), '0, '0, 4'hC, a);
        wait_drain(1'b0);
    endtask

    task automatic test_out_of_range;
        int a;
        drive1(1'b1, BASE - 4, '0, '0, 4'h6, a);
        drive1(1'b1, BASE + 32'(MEM_WORDS * 32), '0, '0, 4'h7, a);
        #1;
        n_checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_opc !== 1'b1 || rsp1.r_data !== '0) begin
            n_errors++; $display("FAIL oor_rsp: got valid %b opc %b data %h required 1/1/0", rsp1.r_valid, rsp1.r_opc, rsp1.r_data);
        end
        wait_drain(1'b0);
        n_checks++;
        if (err1 !== 16'd2) begin n_errors++; $display("FAIL oor_errcnt: got %0d required 2", err1); end
    endtask

    task automatic test_latency_stalls;
        int w, waits, tot_waits, tot_acc;
        logic [DATA_W-1:0] d;
        stall3 = 1'b1;
        req3.lrdy = 1'b1;
        tot_waits = 0;
        tot_acc = 0;
        for (int i = 0; i < 16; i++) begin
            drive3(1'b0, BASE + 32'(i * 32), pat(100 + i), '1, 4'(i), waits);
            tot_waits += waits; tot_acc++;
        end
        for (int n = 0; n < 1000; n++) begin
            w = $urandom_range(0, 15);
            for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
            drive3(1'($urandom_range(0, 1)), BASE + 32'(w * 32) + 32'($urandom_range(0, 31)), d,
                   {$urandom}, 4'($urandom_range(0, 15)), waits);
            tot_waits += waits; tot_acc++;
        end
        wait_drain(1'b1);
        n_checks++;
        if (tot_waits * 100 < (tot_waits + tot_acc) * 15 || tot_waits * 100 > (tot_waits + tot_acc) * 35) begin
            n_errors++; $display("FAIL stall_ratio: got %0d stalled of %0d requesting cycles, required about 25%%", tot_waits, tot_waits + tot_acc);
        end
        n_checks++;
        if (err3 !== 16'd0) begin n_errors++; $display("FAIL stall_errcnt: got %0d required 0", err3); end
        stall3 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int a;
        req1.lrdy = 1'b0;
        drive1(1'b1, BASE + 32'(9 * 32), '0, '0, 4'h1, a);
        drive1(1'b1, BASE + 32'(10 * 32), '0, '0, 4'h2, a);
        drive1(1'b1, BASE + 32'(11 * 32), '0, '0, 4'h3, a);
        #1;
        n_checks++;
        if (nout1 !== 3'd3) begin n_errors++; $display("FAIL rstmid_pre_nout: got %0d required 3", nout1); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp1.r_valid !== 1'b0 || nout1 !== 3'd0 || err1 !== 16'd0) begin
            n_errors++; $display("FAIL rstmid_clear: got valid %b nout %0d err %0d required 0/0/0", rsp1.r_valid, nout1, err1);
        end
        exp_q1.delete(); acc_q1.delete();
        exp_q3.delete(); acc_q3.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req1.lrdy = 1'b1;
        @(negedge clk);
        drive1(1'b1, BASE + 32'(9 * 32), '0, '0, 4'h9, a);
        #1;
        n_checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== pat(9)) begin
            n_errors++; $display("FAIL rstmid_data: got %b/%h required 1/%h", rsp1.r_valid, rsp1.r_data, pat(9));
        end
        wait_drain(1'b0);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        rst = 1'b1;
        req1 = '0; req3 = '0;
        stall1 = 1'b0; stall3 = 1'b0;
        test_reset;
        test_write_read;
        test_byte_enables;
        test_backpressure;
        test_out_of_range;
        test_latency_stalls;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/redmule_tcdm_responder.md
Name: redmule_tcdm_responder

Overview:
- Responder end of the RedMulE wide TCDM data port. Accepts `redmule_default_data_req_t` requests from the streamer and answers with `redmule_default_data_rsp_t`.
- Backed by an internal word-addressed memory, with a configurable read latency, credit-limited outstanding requests, response backpressure via `lrdy`, and optional pseudo-random grant stalls.
- Used as the standalone TCDM model in RedMulE testbenches and in FPGA smoke builds.

Parameters:
- DW, redmule_pkg::DATA_W (256), data width in bits; must be a multiple of 32.
- MEM_WORDS, 1024, depth of the memory in DW-bit words.
- BASE_ADDR, 32'h1000_0000, byte address of word 0.
- LATENCY, 1, cycles from grant to response entering the queue; must be ≥1.
- OUTSTANDING, 4, maximum number of granted but not yet consumed responses; power of 2, ≥2.
- STALL_MASK_W, 2, number of LFSR low bits that must all be zero to force a stall; 0 means never stall.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- stall_en_i  in  1  enables pseudo-random grant stalls.
- req_i  in  redmule_default_data_req_t  request bundle: req, wen (1 = read), be, boffs, add, data, lrdy, user.
- rsp_o  out  redmule_default_data_rsp_t  response bundle: gnt, r_valid, r_data, r_opc, r_user.
- n_outstanding_o  out  $clog2(OUTSTANDING)+1  current credit usage.
- err_cnt_o  out  16  count of out-of-range accesses; saturates at 16'hFFFF.

Behaviour:
- **Reset values.**
  - rsp_o is all zero.
  - n_outstanding_o = 0, err_cnt_o = 0.
  - LFSR = 16'hACE1.
  - Pipeline valids are 0; the queue is empty.
  - Memory contents are not reset.
- **Reset mid-operation.** All in-flight responses are dropped and credits return to 0. Memory keeps its contents.
- **Address decode.**
  - off = add − BASE_ADDR.
  - idx = off >> $clog2(DW/8); the low $clog2(DW/8) bits are ignored.
  - boffs is ignored.
  - Out of range means add < BASE_ADDR or idx ≥ MEM_WORDS.
- **Stall.**
  - LFSR polynomial x^16+x^14+x^13+x^11+1, advancing every cycle.
  - stall = stall_en_i && (STALL_MASK_W > 0) && (lfsr[STALL_MASK_W-1:0] == 0).
- **Grant.** gnt = req && !stall && (n_outstanding < OUTSTANDING). gnt is combinational from req_i and state; the request is accepted on the clock edge when gnt=1.
- **Accepted write (wen=0).**
  - Bytes with be[i]=1 are written at that edge; out-of-range writes are dropped.
  - A response is generated with r_data = 0.
- **Accepted read (wen=1).** r_data = mem[idx] sampled at the accept edge, so a read issued after a write to the same word returns the new data.
- **Out-of-range access.** r_data = 0, r_opc = 1, and err_cnt is incremented.
- **In-range access.** r_opc = 0.
- **r_user.** r_user = user sampled at accept.
- **Response path.**
  - Each accepted response travels through a LATENCY-deep shift pipeline, then enters an OUTSTANDING-deep FIFO.
  - rsp_o.r_valid = FIFO not empty; r_data, r_opc and r_user come from the FIFO head.
  - The FIFO pops on r_valid && lrdy.
  - With an empty FIFO and lrdy=1, the response appears on rsp_o exactly LATENCY cycles after the accept edge (LATENCY=1: the next cycle).
  - While r_valid=1 and lrdy=0, r_data, r_opc and r_user are held stable.
- **Credits.**
  - n_outstanding increments on accept and decrements on pop; accept and pop in the same cycle leave it unchanged.
  - Because of the credit limit, the FIFO can never overflow; an assertion checks this.
- **Ordering.** Responses are strictly in accept order.
- **Throughput.** With lrdy=1 and no stalls: one accept per cycle, sustained.

Decomposition:
- redmule_pkg additions:
  - `TCDM_RSP_OK` = 1'b0, `TCDM_RSP_ERR` = 1'b1 (r_opc codes).
  - `TCDM_LFSR_SEED` = 16'hACE1.
- One sub-module: redmule_tcdm_rsp_fifo, a parameterised synchronous FIFO carrying {r_data, r_opc, r_user}, with push/pop/full/empty.

Test Plan:
- **Write then read.** Write 256'h…DEAD_BEEF at BASE_ADDR+32 with be all ones, then read the same address → r_valid 1 cycle after accept, r_data = written value, r_opc = 0.
- **Byte enables.** Pre-load the word with all 0xFF, write 0x00 with be = 32'h0000_000F, read → low 4 bytes 0x00, remaining bytes 0xFF.
- **Backpressure.** Hold lrdy=0 and issue 6 back-to-back reads → exactly 4 granted, gnt low afterwards, n_outstanding_o = 4, r_data held. Raise lrdy → 4 responses in order, then gnt returns.
- **Out of range.** Read at BASE_ADDR−4 and at BASE_ADDR + MEM_WORDS*32 → r_opc = 1, r_data = 0, err_cnt_o = 2.
- **Latency and stalls.** Set LATENCY=3, stall_en_i=1, 1000 random reads and writes against a scoreboard → every read matches the scoreboard, responses arrive ≥3 cycles after accept, gnt low on roughly 25% of requesting cycles.
- **Reset mid-operation.** Assert rst_i with 3 responses outstanding → rsp_o.r_valid = 0 and n_outstanding_o = 0 immediately; a subsequent read returns the data written before reset.
